// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, request classes, error codes and FSM states.
package riscv_pkg;

   typedef enum logic [3:0] {
      OP_R      = 4'd0,
      OP_IALU   = 4'd1,
      OP_LOAD   = 4'd2,
      OP_STORE  = 4'd3,
      OP_BRANCH = 4'd4,
      OP_JAL    = 4'd5,
      OP_JALR   = 4'd6,
      OP_LUI    = 4'd7,
      OP_AUIPC  = 4'd8
   } req_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_IMM  = 2'd1,
      ERR_OP   = 2'd2,
      ERR_FULL = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

endpackage

// File: rtl/riscv_instr_pack.sv
// Combinational field packer: decoded fields -> 32-bit RV32I word plus legality flags.
module riscv_instr_pack
   import riscv_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        imm_err,
   output logic        op_err
);

   logic signed [31:0] simm;
   logic               is_shift;
   logic               fits_i12;
   logic               fits_b13;
   logic               fits_j21;

   assign simm     = imm;
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign fits_i12 = (simm >= -32'sd2048) && (simm <= 32'sd2047);
   assign fits_b13 = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
   assign fits_j21 = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];

   // Select the instruction format for the class and flag immediates that do not fit it.
   always_comb begin
      word    = '0;
      imm_err = 1'b0;
      op_err  = 1'b0;
      case (op)
         OP_R: word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
         OP_IALU: begin
            if (is_shift) begin
               word    = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
               imm_err = (imm > 32'd31);
            end else begin
               word    = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
               imm_err = !fits_i12;
            end
         end
         OP_LOAD: begin
            word    = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            imm_err = !fits_i12;
         end
         OP_JALR: begin
            word    = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            imm_err = !fits_i12;
         end
         OP_STORE: begin
            word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            imm_err = !fits_i12;
         end
         OP_BRANCH: begin
            word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            imm_err = !fits_b13;
         end
         OP_JAL: begin
            word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            imm_err = !fits_j21;
         end
         OP_LUI: begin
            word    = {imm[31:12], rd, OPC_LUI};
            imm_err = (imm[11:0] != 12'd0);
         end
         OP_AUIPC: begin
            word    = {imm[31:12], rd, OPC_AUIPC};
            imm_err = (imm[11:0] != 12'd0);
         end
         default: op_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/riscv_instr_encoder.sv
// Instruction encoder: accepts field requests, packs them and streams words to instruction memory.
//
// state   | meaning
// ST_IDLE | waiting for start, no requests accepted
// ST_RUN  | accepting requests, writing sequential words from base
// ST_ERR  | stopped on bad request or full; pending word drains, start resumes
module riscv_instr_encoder
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [3:0]               req_op,
   input  logic [4:0]               req_rd,
   input  logic [4:0]               req_rs1,
   input  logic [4:0]               req_rs2,
   input  logic [2:0]               req_funct3,
   input  logic [6:0]               req_funct7,
   input  logic [31:0]              req_imm,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [31:0]              wr_data,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [$clog2(DEPTH):0]   word_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(3);

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  next_addr;
   logic [CNT_W-1:0]   issued_cnt;
   err_code_e          err_code_q;
   logic [31:0]        pack_word;
   logic               imm_err, op_err;
   logic               full, out_free, accept, bad_req;

   riscv_instr_pack u_pack (
      .op      (req_op),
      .rd      (req_rd),
      .rs1     (req_rs1),
      .rs2     (req_rs2),
      .funct3  (req_funct3),
      .funct7  (req_funct7),
      .imm     (req_imm),
      .word    (pack_word),
      .imm_err (imm_err),
      .op_err  (op_err)
   );

   // Issued count includes the pending word so full stops intake one word early enough.
   assign full     = (issued_cnt == CNT_FULL);
   assign out_free = !wr_valid || wr_ready;
   assign accept   = req_valid && req_ready;
   assign bad_req  = imm_err || op_err;
   assign err_code = err_code_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state and request handshake; start overrides any acceptance in the same cycle.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
               req_ready = out_free && !full;
               if (req_valid && req_ready && bad_req) state_d = ST_ERR;
               else if (full && out_free)             state_d = ST_ERR;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output register, address counter, word counters and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         next_addr  <= '0;
         issued_cnt <= '0;
         word_count <= '0;
         err        <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         if (wr_valid && wr_ready) begin
            wr_valid   <= 1'b0;
            word_count <= word_count + CNT_ONE;
         end
         if (start) begin
            next_addr  <= base_addr & ADDR_ALIGN;
            issued_cnt <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
         end else if (accept) begin
            if (bad_req) begin
               err        <= 1'b1;
               err_code_q <= op_err ? ERR_OP : ERR_IMM;
            end else begin
               wr_valid   <= 1'b1;
               wr_addr    <= next_addr;
               wr_data    <= pack_word;
               next_addr  <= next_addr + ADDR_STEP;
               issued_cnt <= issued_cnt + CNT_ONE;
            end
         end else if (state_q == ST_RUN && full) begin
            err        <= 1'b1;
            err_code_q <= ERR_FULL;
         end
      end
   end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Scoreboard bench for riscv_instr_encoder: directed program fragments plus randomized bursts.
module tb_riscv_instr_encoder;

   localparam int ADDR_W = 9;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [4:0]        req_rd, req_rs1, req_rs2;
   logic [2:0]        req_funct3;
   logic [6:0]        req_funct7;
   logic [31:0]       req_imm;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              err;
   logic [1:0]        err_code;
   logic [2:0]        word_count;

   int total = 0;
   int bad   = 0;

   exp_t sb_q[$];

   // model of the encoder's bookkeeping since the last start
   logic [ADDR_W-1:0] m_addr;
   int                m_issued;
   bit                m_stop;
   int                m_code;

   int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

   logic [31:0] bnd [16] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd31, 32'd32,
                             32'd4094, 32'd4096, -32'd4096, -32'd4098, 32'd1048574,
                             32'd1048576, -32'd1048576, 32'd3, 32'h12345000, 32'h12345001};

   riscv_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_funct3 (req_funct3),
      .req_funct7 (req_funct7),
      .req_imm    (req_imm),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .err        (err),
      .err_code   (err_code),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // memory-side ready generator
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       wr_ready = ($urandom_range(0, 3) != 0);
         1:       wr_ready = 1'b1;
         default: wr_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
      end
   endtask

   // Reference encoder written from the RV32I field layouts with integer range checks.
   function automatic void ref_encode(input int op, input logic [31:0] rd, rs1, rs2, f3, f7,
                                      input logic [31:0] imm, output logic [31:0] w,
                                      output int code);
      longint si;
      si   = longint'($signed(imm));
      code = 0;
      w    = 32'd0;
      case (op)
         0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         1: begin
            if (f3 == 1 || f3 == 5) begin
               if (si < 0 || si > 31) code = 1;
               w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end else begin
               if (si < -2048 || si > 2047) code = 1;
               w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
         end
         2: begin
            if (si < -2048 || si > 2047) code = 1;
            w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         end
         6: begin
            if (si < -2048 || si > 2047) code = 1;
            w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
         end
         3: begin
            if (si < -2048 || si > 2047) code = 1;
            w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((imm & 32'h1F) << 7) | 32'h23;
         end
         4: begin
            if (si < -4096 || si > 4094 || (si % 2) != 0) code = 1;
            w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
              | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7) | 32'h63;
         end
         5: begin
            if (si < -1048576 || si > 1048574 || (si % 2) != 0) code = 1;
            w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
              | (rd << 7) | 32'h6F;
         end
         7, 8: begin
            if ((imm & 32'hFFF) != 0) code = 1;
            w = (imm & 32'hFFFFF000) | (rd << 7) | ((op == 7) ? 32'h37 : 32'h17);
         end
         default: code = 2;
      endcase
   endfunction

   // Monitor: every memory handshake pops one expected word; stalled words must hold.
   bit                stall_prev = 0;
   logic [ADDR_W-1:0] stall_addr;
   logic [31:0]       stall_data;
   always @(negedge clk) begin
      if (!reset) begin
         if (stall_prev) begin
            total++;
            if (!wr_valid || wr_addr !== stall_addr || wr_data !== stall_data) begin
               bad++;
               $display("FAIL hold: got v=%0b a=0x%03h d=0x%08h want v=1 a=0x%03h d=0x%08h",
                        wr_valid, wr_addr, wr_data, stall_addr, stall_data);
            end
         end
         if (wr_valid && wr_ready) begin
            exp_t e;
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write: got a=0x%03h d=0x%08h want no write", wr_addr, wr_data);
            end else begin
               e = sb_q.pop_front();
               if (wr_addr !== e.addr || wr_data !== e.data) begin
                  bad++;
                  $display("FAIL write: got a=0x%03h d=0x%08h want a=0x%03h d=0x%08h",
                           wr_addr, wr_data, e.addr, e.data);
               end
            end
         end
         stall_prev = wr_valid && !wr_ready;
         stall_addr = wr_addr;
         stall_data = wr_data;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic do_start(input logic [ADDR_W-1:0] base);
      start     = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      start    = 1'b0;
      m_addr   = base & ~ADDR_W'(3);
      m_issued = 0;
      m_stop   = 0;
      m_code   = 0;
   endtask

   task automatic send(input int op, input int rd, input int rs1, input int rs2, input int f3,
                       input int f7, input logic [31:0] imm, input bit use_exp,
                       input logic [31:0] exp_w);
      logic [31:0] w;
      int          code;
      bit          exp_acc, acc;
      int          lim;
      ref_encode(op, 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm, w, code);
      if (use_exp) w = exp_w;
      exp_acc    = !m_stop;
      req_op     = 4'(op);
      req_rd     = 5'(rd);
      req_rs1    = 5'(rs1);
      req_rs2    = 5'(rs2);
      req_funct3 = 3'(f3);
      req_funct7 = 7'(f7);
      req_imm    = imm;
      req_valid  = 1'b1;
      acc        = 0;
      lim        = exp_acc ? 60 : 6;
      for (int c = 0; c < lim; c++) begin
         @(negedge clk);
         if (req_ready) acc = 1;
         @(posedge clk); #1;
         if (acc) break;
      end
      req_valid = 1'b0;
      chk($sformatf("accept_op%0d", op), 32'(acc), 32'(exp_acc));
      if (acc && exp_acc) begin
         if (code == 0) begin
            sb_q.push_back('{m_addr, w});
            m_addr = m_addr + ADDR_W'(4);
            m_issued++;
            chk("latency_wr_valid", 32'(wr_valid), 32'd1);
            if (m_issued == DEPTH) begin
               m_stop = 1;
               m_code = 3;
            end
         end else begin
            m_stop = 1;
            m_code = code;
         end
      end
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !wr_valid) begin
            done = 1;
            break;
         end
      end
      chk("drain", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_status();
      chk("err", 32'(err), (m_code != 0) ? 32'd1 : 32'd0);
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("word_count", 32'(word_count), 32'(m_issued));
   endtask

   function automatic logic [31:0] rnd_imm();
      case ($urandom_range(0, 5))
         0:       return 32'($urandom_range(0, 63)) - 32'd32;
         1:       return bnd[$urandom_range(0, 15)];
         2:       return $urandom;
         3:       return (32'($urandom_range(0, 2047)) << 2) - 32'd4096;
         4:       return $urandom << 12;
         default: return (32'($urandom_range(0, 1048575)) << 1) - 32'd1048576;
      endcase
   endfunction

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      req_valid  = 1'b0;
      req_op     = '0;
      req_rd     = '0;
      req_rs1    = '0;
      req_rs2    = '0;
      req_funct3 = '0;
      req_funct7 = '0;
      req_imm    = '0;
      wr_ready   = 1'b0;
      m_addr     = '0;
      m_issued   = 0;
      m_stop     = 0;
      m_code     = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_req_ready", 32'(req_ready), 32'd0);

      // addi x1,x0,5
      do_start(9'h040);
      send(1, 1, 0, 0, 0, 0, 32'd5, 1, 32'h00500093);
      wait_drain();

      // add x3,x1,x2 ; sw x2,8(x1) back to back
      do_start(9'h040);
      send(0, 3, 1, 2, 0, 0, 32'd0, 1, 32'h002081B3);
      send(3, 0, 1, 2, 2, 0, 32'd8, 1, 32'h0020A423);
      wait_drain();
      check_status();

      // beq x1,x2,-8 with memory stalled for three cycles
      rdy_mode = 2;
      @(posedge clk); #1;
      send(4, 0, 1, 2, 0, 0, -32'd8, 1, 32'hFE208CE3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_wr_valid", 32'(wr_valid), 32'd1);
         chk("stall_wr_data", wr_data, 32'hFE208CE3);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      rdy_mode = 1;
      wait_drain();
      check_status();

      // jal x1,2048 ; lui x5,0x12345000
      do_start(9'h080);
      send(5, 1, 0, 0, 0, 0, 32'd2048, 1, 32'h001000EF);
      send(7, 5, 0, 0, 0, 0, 32'h12345000, 1, 32'h123452B7);
      wait_drain();
      check_status();

      // misaligned branch offset stops the encoder until restarted
      do_start(9'h0C0);
      send(4, 0, 1, 2, 0, 0, 32'd3, 0, 32'd0);
      wait_drain();
      check_status();
      chk("err_req_ready", 32'(req_ready), 32'd0);
      do_start(9'h101);
      chk("restart_err", 32'(err), 32'd0);
      send(1, 2, 1, 0, 0, 0, -32'd1, 0, 32'd0);
      wait_drain();
      check_status();

      // fill to DEPTH across the address wrap; fifth request refused
      do_start(9'h1F8);
      for (int i = 0; i < 5; i++) send(1, i + 1, 0, 0, 0, 0, 32'(i), 0, 32'd0);
      wait_drain();
      check_status();

      // illegal class
      do_start(9'h000);
      send(9, 1, 1, 1, 0, 0, 32'd0, 0, 32'd0);
      wait_drain();
      check_status();

      // randomized bursts
      rdy_mode = 0;
      for (int it = 0; it < 40; it++) begin
         int n;
         do_start(ADDR_W'($urandom));
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            int op;
            op = ($urandom_range(0, 19) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 127), rnd_imm(), 0, 32'd0);
         end
         wait_drain();
         check_status();
      end
      rdy_mode = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
